// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the two-master block-RAM arbiter.
// Holds the FSM state encoding, the master indices and the default bus widths.
package ram_bus_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_t;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the last-grant register lives in the parent.
// On a tie the master that did not win last time is chosen.
module rr_arb2
    import ram_bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = onehot(M0);
            2'b10:   o_gnt = onehot(M1);
            2'b11:   o_gnt = onehot(~i_last_grant);
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares one single-port synchronous-read block RAM between two req/ready bus masters.
// state | meaning: IDLE arbitrate | ISSUE drive RAM | WAIT read latency | RESP ready pulse
module ram_bus_arbiter
    import ram_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_ready,

    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_ready,

    output logic [ADDR_W-1:0] o_ram_addra,
    output logic              o_ram_wea,
    output logic [DATA_W-1:0] o_ram_dina,
    input  logic [DATA_W-1:0] i_ram_douta,

    output logic [1:0]        o_grant,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_conflict_cnt
);

    // Down-counter preload: terminal count 0 marks the cycle douta is valid.
    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    state_t            r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_we;
    logic [1:0]        r_wait_cnt;
    logic [1:0]        r_grant;
    logic [ADDR_W-1:0] r_ram_addra;
    logic [DATA_W-1:0] r_ram_dina;
    logic              r_ram_wea;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              r_m0_ready;
    logic              r_m1_ready;
    logic [CNT_W-1:0]  r_conflict_cnt;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_tie;
    logic              w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_req   = {i_m1_req, i_m0_req};
    assign w_tie   = &w_req;
    assign w_sel   = w_gnt[1];
    assign w_we    = w_sel ? i_m1_we    : i_m0_we;
    assign w_addr  = w_sel ? i_m1_addr  : i_m0_addr;
    assign w_wdata = w_sel ? i_m1_wdata : i_m0_wdata;

    rr_arb2 u_arb (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_gnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_owner        <= M0;
            r_last_grant   <= M1;
            r_we           <= 1'b0;
            r_wait_cnt     <= 2'd0;
            r_grant        <= 2'b00;
            r_ram_addra    <= '0;
            r_ram_dina     <= '0;
            r_ram_wea      <= 1'b0;
            r_m0_rdata     <= '0;
            r_m1_rdata     <= '0;
            r_m0_ready     <= 1'b0;
            r_m1_ready     <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_m0_ready <= 1'b0;
            r_m1_ready <= 1'b0;
            r_ram_wea  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_owner      <= w_sel;
                        r_last_grant <= w_sel;
                        r_grant      <= w_gnt;
                        r_we         <= w_we;
                        r_ram_addra  <= w_addr;
                        r_ram_dina   <= w_wdata;
                        r_ram_wea    <= w_we;
                        if (w_tie && (r_conflict_cnt != {CNT_W{1'b1}}))
                            r_conflict_cnt <= r_conflict_cnt + 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_grant <= 2'b00;
                        if (r_owner == M1) r_m1_ready <= 1'b1;
                        else               r_m0_ready <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_wait_cnt <= WAIT_LOAD;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_grant <= 2'b00;
                        if (r_owner == M1) begin
                            r_m1_rdata <= i_ram_douta;
                            r_m1_ready <= 1'b1;
                        end else begin
                            r_m0_rdata <= i_ram_douta;
                            r_m0_ready <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_m0_rdata     = r_m0_rdata;
    assign o_m0_ready     = r_m0_ready;
    assign o_m1_rdata     = r_m1_rdata;
    assign o_m1_ready     = r_m1_ready;
    assign o_ram_addra    = r_ram_addra;
    assign o_ram_wea      = r_ram_wea;
    assign o_ram_dina     = r_ram_dina;
    assign o_grant        = r_grant;
    assign o_busy         = (r_state != IDLE);
    assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: one instance with RD_LAT=1 (a_*) and one with RD_LAT=3 (b_*),
// each behind a small block-RAM model; ready pulses are matched against a scoreboard.
module tb_ram_bus_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A, RD_LAT = 1 ----------------
    logic          a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
    logic [AW-1:0] a_m0_addr = '0, a_m1_addr = '0;
    logic [DW-1:0] a_m0_wdata = '0, a_m1_wdata = '0;
    logic [DW-1:0] a_m0_rdata, a_m1_rdata;
    logic          a_m0_ready, a_m1_ready;
    logic [AW-1:0] a_addra;
    logic          a_wea;
    logic [DW-1:0] a_dina;
    logic [DW-1:0] a_douta = '0;
    logic [1:0]    a_grant;
    logic          a_busy;
    logic [CW-1:0] a_cnt;

    ram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .CNT_W(CW)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(a_m0_req), .i_m0_we(a_m0_we), .i_m0_addr(a_m0_addr), .i_m0_wdata(a_m0_wdata),
        .o_m0_rdata(a_m0_rdata), .o_m0_ready(a_m0_ready),
        .i_m1_req(a_m1_req), .i_m1_we(a_m1_we), .i_m1_addr(a_m1_addr), .i_m1_wdata(a_m1_wdata),
        .o_m1_rdata(a_m1_rdata), .o_m1_ready(a_m1_ready),
        .o_ram_addra(a_addra), .o_ram_wea(a_wea), .o_ram_dina(a_dina), .i_ram_douta(a_douta),
        .o_grant(a_grant), .o_busy(a_busy), .o_conflict_cnt(a_cnt)
    );

    logic [DW-1:0] mem_a [1024];
    always @(posedge clk) begin
        if (a_wea) mem_a[a_addra] <= a_dina;
        a_douta <= mem_a[a_addra];
    end

    // ---------------- instance B, RD_LAT = 3 ----------------
    logic          b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
    logic [AW-1:0] b_m0_addr = '0, b_m1_addr = '0;
    logic [DW-1:0] b_m0_wdata = '0, b_m1_wdata = '0;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata;
    logic          b_m0_ready, b_m1_ready;
    logic [AW-1:0] b_addra;
    logic          b_wea;
    logic [DW-1:0] b_dina;
    logic [DW-1:0] b_douta = '0, b_p1 = '0, b_p2 = '0;
    logic [1:0]    b_grant;
    logic          b_busy;
    logic [CW-1:0] b_cnt;
    logic          b_pre_we = 0;
    logic [AW-1:0] b_pre_addr = '0;
    logic [DW-1:0] b_pre_data = '0;

    ram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .CNT_W(CW)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(b_m0_req), .i_m0_we(b_m0_we), .i_m0_addr(b_m0_addr), .i_m0_wdata(b_m0_wdata),
        .o_m0_rdata(b_m0_rdata), .o_m0_ready(b_m0_ready),
        .i_m1_req(b_m1_req), .i_m1_we(b_m1_we), .i_m1_addr(b_m1_addr), .i_m1_wdata(b_m1_wdata),
        .o_m1_rdata(b_m1_rdata), .o_m1_ready(b_m1_ready),
        .o_ram_addra(b_addra), .o_ram_wea(b_wea), .o_ram_dina(b_dina), .i_ram_douta(b_douta),
        .o_grant(b_grant), .o_busy(b_busy), .o_conflict_cnt(b_cnt)
    );

    logic [DW-1:0] mem_b [1024];
    always @(posedge clk) begin
        if (b_wea)         mem_b[b_addra]    <= b_dina;
        else if (b_pre_we) mem_b[b_pre_addr] <= b_pre_data;
        b_p1    <= mem_b[b_addra];
        b_p2    <= b_p1;
        b_douta <= b_p2;
    end

    // ---------------- scoreboard ----------------
    // q[0]=a_m0, q[1]=a_m1, q[2]=b_m0, q[3]=b_m1
    exp_t          q [4][$];
    logic [DW-1:0] shadow_a [1024];
    logic [DW-1:0] hold_a0 = '0, hold_a1 = '0;

    function automatic string pname(input int p);
        case (p)
            0:       return "a_m0";
            1:       return "a_m1";
            2:       return "b_m0";
            default: return "b_m1";
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int p, input logic rdy, input logic [DW-1:0] rd);
        exp_t e;
        if (rdy) begin
            n_checks++;
            assert (q[p].size() > 0) else begin
                n_fail++;
                $error("FAIL %s_ready_unexpected: observed ready=1 at cycle %0d required no pending transaction",
                       pname(p), cyc);
            end
            if (q[p].size() > 0) begin
                e = q[p].pop_front();
                check({pname(p), "_ready_cycle"}, 64'(cyc), 64'(e.cyc));
                check({pname(p), "_rdata"}, 64'(rd), 64'(e.data));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_m0_ready, a_m0_rdata);
        mon(1, a_m1_ready, a_m1_rdata);
        mon(2, b_m0_ready, b_m0_rdata);
        mon(3, b_m1_ready, b_m1_rdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one transaction on instance A, wait (bounded) for its ready, release and idle a cycle.
    task automatic do_txn_a(input logic m, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input string tag);
        exp_t e;
        logic seen;
        e.cyc = cyc + (we ? 2 : 3);
        if (we) begin
            shadow_a[addr] = data;
            e.data = m ? hold_a1 : hold_a0;
        end else begin
            e.data = shadow_a[addr];
            if (m) hold_a1 = e.data;
            else   hold_a0 = e.data;
        end
        if (m) begin
            q[1].push_back(e);
            a_m1_req = 1; a_m1_we = we; a_m1_addr = addr; a_m1_wdata = data;
        end else begin
            q[0].push_back(e);
            a_m0_req = 1; a_m0_we = we; a_m0_addr = addr; a_m0_wdata = data;
        end
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = m ? a_m1_ready : a_m0_ready;
        end
        check({tag, "_done"}, 64'(seen), 64'd1);
        if (m) a_m1_req = 0;
        else   a_m0_req = 0;
        tick();
    endtask

    initial begin
        int   t0;
        logic seen;
        exp_t e;

        // reset state
        rst = 1;
        tick(); tick();
        check("rst_grant", a_grant, 0);
        check("rst_busy", a_busy, 0);
        check("rst_m0_ready", a_m0_ready, 0);
        check("rst_m1_ready", a_m1_ready, 0);
        check("rst_m0_rdata", a_m0_rdata, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_wea", a_wea, 0);
        check("rst_addra", a_addra, 0);
        rst = 0;
        tick();

        // m0 write 0x005 <= DEADBEEF
        t0 = cyc;
        a_m0_req = 1; a_m0_we = 1; a_m0_addr = 10'h005; a_m0_wdata = 32'hDEADBEEF;
        shadow_a[10'h005] = 32'hDEADBEEF;
        e.cyc = t0 + 2; e.data = hold_a0; q[0].push_back(e);
        check("wr_c0_wea", a_wea, 0);
        tick();
        check("wr_c1_wea", a_wea, 1);
        check("wr_c1_addra", a_addra, 10'h005);
        check("wr_c1_dina", a_dina, 32'hDEADBEEF);
        check("wr_c1_grant", a_grant, 2'b01);
        check("wr_c1_busy", a_busy, 1);
        tick();
        check("wr_c2_wea", a_wea, 0);
        check("wr_c2_m1_ready", a_m1_ready, 0);
        a_m0_req = 0;
        tick();
        check("wr_c3_busy", a_busy, 0);
        check("wr_c3_grant", a_grant, 0);
        check("wr_c3_addra_hold", a_addra, 10'h005);
        check("wr_c3_dina_hold", a_dina, 32'hDEADBEEF);

        // m0 read back, m1 write, m0 rdata untouched by m1 write
        do_txn_a(0, 0, 10'h005, '0, "rd_m0");
        check("rd_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        check("rd_m1_rdata_zero", a_m1_rdata, 0);
        do_txn_a(1, 1, 10'h00A, 32'hCAFEF00D, "wr_m1");
        check("wr_m1_m0_rdata_hold", a_m0_rdata, 32'hDEADBEEF);

        // tie after reset: m0 first, m1 four cycles later
        rst = 1; tick(); rst = 0;
        hold_a0 = '0; hold_a1 = '0;
        check("tie_rst_m0_rdata", a_m0_rdata, 0);
        tick();
        t0 = cyc;
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 10'h005;
        a_m1_req = 1; a_m1_we = 0; a_m1_addr = 10'h00A;
        e.cyc = t0 + 3; e.data = 32'hDEADBEEF; q[0].push_back(e); hold_a0 = e.data;
        e.cyc = t0 + 7; e.data = 32'hCAFEF00D; q[1].push_back(e); hold_a1 = e.data;
        tick();
        check("tie_first_grant", a_grant, 2'b01);
        tick(); tick();
        a_m0_req = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = a_m1_ready;
        end
        check("tie_m1_done", seen, 1);
        a_m1_req = 0;
        tick();
        check("tie_cnt", a_cnt, 1);
        check("tie_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
        check("tie_m1_rdata", a_m1_rdata, 32'hCAFEF00D);

        // fairness: both hold write requests for 8 transactions
        t0 = cyc;
        a_m0_req = 1; a_m0_we = 1; a_m0_addr = 10'h030; a_m0_wdata = 32'h11111111;
        a_m1_req = 1; a_m1_we = 1; a_m1_addr = 10'h031; a_m1_wdata = 32'h22222222;
        shadow_a[10'h030] = 32'h11111111;
        shadow_a[10'h031] = 32'h22222222;
        for (int k = 0; k < 8; k++) begin
            e.cyc = t0 + 3 * k + 2;
            e.data = (k % 2 == 0) ? hold_a0 : hold_a1;
            q[k % 2].push_back(e);
        end
        for (int c = 1; c <= 23; c++) begin
            tick();
            check($sformatf("fair_wea_c%0d", c), a_wea, (c % 3 == 1) ? 1 : 0);
            if (c % 3 == 1)
                check($sformatf("fair_grant_c%0d", c), a_grant, ((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
        end
        a_m0_req = 0; a_m1_req = 0;
        tick();
        check("fair_cnt", a_cnt, 9);
        check("fair_busy", a_busy, 0);

        // reset in WAIT of an m0 read
        t0 = cyc;
        a_m0_req = 1; a_m0_we = 0; a_m0_addr = 10'h00A;
        tick(); tick();
        rst = 1; a_m0_req = 0;
        tick();
        check("rstw_grant", a_grant, 0);
        check("rstw_busy", a_busy, 0);
        check("rstw_m0_ready", a_m0_ready, 0);
        check("rstw_m0_rdata", a_m0_rdata, 0);
        check("rstw_wea", a_wea, 0);
        check("rstw_cnt", a_cnt, 0);
        rst = 0;
        hold_a0 = '0; hold_a1 = '0;
        tick();
        do_txn_a(0, 0, 10'h00A, '0, "rstw_reissue");
        check("rstw_reissue_rdata", a_m0_rdata, 32'hCAFEF00D);

        // RD_LAT=3 instance: m1 read of preloaded 0x3FF
        b_pre_we = 1; b_pre_addr = 10'h3FF; b_pre_data = 32'h12345678;
        tick();
        b_pre_we = 0;
        tick();
        t0 = cyc;
        b_m1_req = 1; b_m1_we = 0; b_m1_addr = 10'h3FF;
        e.cyc = t0 + 5; e.data = 32'h12345678; q[3].push_back(e);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("lat3_addra_c%0d", c), b_addra, 10'h3FF);
            check($sformatf("lat3_wea_c%0d", c), b_wea, 0);
            check($sformatf("lat3_ready_c%0d", c), b_m1_ready, 0);
        end
        tick();
        check("lat3_ready_c5", b_m1_ready, 1);
        b_m1_req = 0;
        tick();
        check("lat3_m1_rdata", b_m1_rdata, 32'h12345678);
        check("lat3_m0_rdata", b_m0_rdata, 0);

        tick(); tick();
        for (int p = 0; p < 4; p++)
            check({pname(p), "_pending"}, 64'(q[p].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
